priority_demux_1to6: RTL and testbench
======================================

Name: priority_demux_1to6

Overview:
- Buffered 1-to-6 priority demultiplexer. It is the distribution end of the 6-to-1 priority mux path.
- One WIDTH-bit input stream with a 5-bit select is routed to one of six output channels. The routing uses the same priority decode the mux applies.
- Each channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer back-pressures only traffic addressed to it.
- Per-channel wrapping acceptance counters support bring-up and debug.

Parameters:
- WIDTH, 8, data width of the input and each output channel.
- SEL_W, 5, select width; the number of channels is fixed at SEL_W+1 = 6.
- CNT_W, 16, width of each per-channel acceptance counter.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat is valid.
- in_ready  out  1  input beat accepted this cycle when in_valid is also high.
- in_data  in  WIDTH  input payload.
- in_sel  in  SEL_W  priority select; held stable with in_data while in_valid is high.
- flush  in  1  synchronous clear of all holding registers.
- out_valid  out  6  bit k high means channel k holds data.
- out_ready  in  6  bit k high means the channel k consumer takes data this cycle.
- out_data  out  6*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- acc_cnt  out  6*CNT_W  channel k acceptance count at bits [k*CNT_W +: CNT_W].

Behaviour:
- Channel decode (combinational):
  - ch = 0 if in_sel == 0.
  - Otherwise ch = 1 + index of the highest set bit of in_sel.
  - So sel 1 -> ch1, 2..3 -> ch2, 4..7 -> ch3, 8..15 -> ch4, 16..31 -> ch5.
  - Every value of in_sel maps to a channel; there is no invalid select.
- Per-channel state: full[k] (1 bit), buf[k] (WIDTH bits), cnt[k] (CNT_W bits).
- Outputs:
  - out_valid[k] = full[k] and out_data[k] = buf[k], driven directly from registers.
  - out_valid and out_data have no combinational path from the inputs.
- in_ready = !flush && (!full[ch] || out_ready[ch]).
  - This is combinational from in_sel, out_ready, flush and the full flags.
  - in_ready may be high while in_valid is low.
- Push condition: in_valid && in_ready.
  - On the next edge, buf[ch] <= in_data, full[ch] <= 1 and cnt[ch] <= cnt[ch] + 1.
  - Latency is 1 cycle from accept to out_valid.
- Pop condition for channel k: full[k] && out_ready[k].
  - On the next edge, full[k] <= 0 unless the same channel is pushed in that cycle.
- Simultaneous push and pop on the same channel: buf is replaced with the new data, full stays 1, and the count increments. This gives full throughput of one beat per cycle per channel.
- Push and pop on different channels are independent. More than one channel may pop in one cycle.
- A stall on channel j never blocks a push to channel k != j.
- flush: on the next edge all full[k] clear and buf is unchanged.
  - A flush forces in_ready to 0, so no push occurs in a flush cycle.
  - Counters are not cleared by flush.
- Counters: cnt[k] wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset (async assert, sync deassert handled externally): full = 0, buf = 0, cnt = 0.
  - Consequently out_valid = 0, out_data = 0 and acc_cnt = 0 immediately on assertion.
  - in_ready = 1 after reset, subject to flush.
  - A beat in flight at reset is lost.
- Protocol: a consumer must not make out_ready depend combinationally on in_ready; that would create a loop.
- An X on in_sel while in_valid is low must not affect state.

Decomposition:
- Shared package priority_mux_pkg:
  - NUM_CH = 6.
  - SEL_W = 5.
  - Function sel_to_ch(sel) returning a 3-bit channel index, shared with the 6-to-1 priority mux so both ends decode identically.
- One sub-module: priority_sel_decode (SEL_W in, 3-bit ch plus one-hot 6-bit out, purely combinational), used by this block.
- Per-channel state lives in a generate loop; no separate channel module.

Test Plan:
- Reset, then sweep in_sel 0..31 with in_data = 8'hB8, 8'hF0, 8'h55, 8'h33, 8'hE3, 8'hAA per target channel 0..5 and all out_ready = 1.
  - Each beat appears on exactly the decoded channel one cycle later.
  - Final acc_cnt = {16, 8, 4, 2, 1, 1} for channels 5..0.
- Hold out_ready[3] = 0 and push sel = 5, data 8'h33.
  - out_valid[3] = 1 and a second sel = 6 beat sees in_ready = 0.
  - In the same cycle sel = 9 has in_ready = 1, lands on ch4, and ch3 still holds 8'h33.
- Keep ch2 full with out_ready[2] = 1 and push sel = 3, data 8'h01 then 8'h02 on consecutive cycles.
  - Back-to-back acceptance with in_ready held at 1.
  - ch2 shows 8'h01 then 8'h02; cnt[2] increases by 2.
- Fill ch0, ch1 and ch5 with out_ready = 0, then pulse flush with in_valid = 1.
  - in_ready = 0 during the flush, all out_valid = 0 next cycle, and acc_cnt is unchanged.
- Preload cnt[1] to 16'hFFFF via 65535 pushes at sel = 1; one more push gives cnt[1] = 0.
- Assert rst_n = 0 asynchronously mid-burst between clock edges.
  - out_valid, out_data and acc_cnt go to 0 immediately.
  - After release, a sel = 16 beat with data 8'hAA appears on ch5 after 1 cycle.

Source files
------------

// File: rtl/priority_mux_pkg.sv
// Shared definitions for the 6-channel priority mux/demux path.
// Both ends decode the select through sel_to_ch so their channel maps always agree.
package priority_mux_pkg;

    localparam int NUM_CH = 6;
    localparam int SEL_W  = 5;
    localparam int CH_W   = 3;

    // Channel 0 for a zero select, otherwise one above the highest set bit.
    function automatic logic [CH_W-1:0] sel_to_ch(input logic [SEL_W-1:0] sel);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (sel[i]) ch = CH_W'(i + 1);
        end
        return ch;
    endfunction

endpackage

// File: rtl/priority_demux_1to6_if.sv
// Input stream, per-channel output streams and debug counters of the 1-to-6 demux.
interface priority_demux_1to6_if
    import priority_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);

    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      flush;
    logic [NUM_CH-1:0]         out_valid;
    logic [NUM_CH-1:0]         out_ready;
    logic [NUM_CH*WIDTH-1:0]   out_data;
    logic [NUM_CH*CNT_W-1:0]   acc_cnt;

    modport master (
        output in_valid, in_data, in_sel, flush, out_ready,
        input  in_ready, out_valid, out_data, acc_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, flush, out_ready,
        output in_ready, out_valid, out_data, acc_cnt
    );

endinterface

// File: rtl/priority_demux_1to6_sel_decode.sv
// Combinational select decode: channel index plus the matching one-hot vector.
module priority_sel_decode
    import priority_mux_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    output logic [CH_W-1:0]   ch,
    output logic [NUM_CH-1:0] ch_oh
);

    assign ch = sel_to_ch(sel);

    always_comb begin
        ch_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_oh[i] = (ch == CH_W'(i));
        end
    end

endmodule

// File: rtl/priority_demux_1to6.sv
// Buffered 1-to-6 priority demux: one holding register per channel, so a stalled
// consumer only back-pressures beats addressed to its own channel.
module priority_demux_1to6
    import priority_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_demux_1to6_if.slave bus
);

    logic [CH_W-1:0]   ch;
    logic [NUM_CH-1:0] ch_oh;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push_oh;
    logic              push;

    priority_sel_decode u_sel_decode (
        .sel   (bus.in_sel),
        .ch    (ch),
        .ch_oh (ch_oh)
    );

    // One-hot select keeps an X select harmless once in_valid gates the push.
    assign bus.in_ready = !bus.flush && (|(ch_oh & (~full | bus.out_ready)));
    assign push         = bus.in_valid && bus.in_ready;
    assign push_oh      = ch_oh & {NUM_CH{push}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic             full_q;
        logic [WIDTH-1:0] buf_q;
        logic [CNT_W-1:0] cnt_q;

        // A push wins over pop and flush; flush never coincides with a push.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                full_q <= 1'b0;
                buf_q  <= '0;
                cnt_q  <= '0;
            end else if (push_oh[k]) begin
                full_q <= 1'b1;
                buf_q  <= bus.in_data;
                cnt_q  <= cnt_q + 1'b1;
            end else if (bus.flush || bus.out_ready[k]) begin
                full_q <= 1'b0;
            end
        end

        assign full[k]                         = full_q;
        assign bus.out_valid[k]                = full_q;
        assign bus.out_data[k*WIDTH +: WIDTH]  = buf_q;
        assign bus.acc_cnt[k*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: tb/tb_priority_demux_1to6.sv
// Directed self-checking bench for priority_demux_1to6.
module tb_priority_demux_1to6;
    import priority_mux_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_cnt [NUM_CH];
    logic [WIDTH-1:0] data_tab [NUM_CH];

    priority_demux_1to6_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    priority_demux_1to6 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent range-compare model of the select decode.
    function automatic int exp_ch(input int sel);
        if (sel == 0) return 0;
        else if (sel < 2) return 1;
        else if (sel < 4) return 2;
        else if (sel < 8) return 3;
        else if (sel < 16) return 4;
        else return 5;
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] exp_acc();
        logic [NUM_CH*CNT_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(exp_cnt[i]);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int sel, input logic [WIDTH-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = SEL_W'(sel);
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_valid got %b exp %b", bus.out_valid, 6'b0);
        end
        checks++;
        if (bus.out_data !== '0 || bus.acc_cnt !== '0) begin
            errors++; $display("[TB] FAIL reset_data_cnt got %h/%h exp 0/0", bus.out_data, bus.acc_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready got %b exp 1", bus.in_ready);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) exp_cnt[i] = 0;
    endtask

    task automatic test_sweep();
        int c;
        bus.out_ready = 6'h3F;
        for (int s = 0; s < 32; s++) begin
            c = exp_ch(s);
            drive(1'b1, s, data_tab[c]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL sweep_ready sel %0d got %b exp 1", s, bus.in_ready);
            end
            step();
            exp_cnt[c]++;
            checks++;
            if (bus.out_valid !== (6'b1 << c) || bus.out_data[c*WIDTH +: WIDTH] !== data_tab[c]) begin
                errors++;
                $display("[TB] FAIL sweep_route sel %0d got valid %b data %h exp valid %b data %h",
                         s, bus.out_valid, bus.out_data[c*WIDTH +: WIDTH], 6'b1 << c, data_tab[c]);
            end
        end
        drive(1'b0, 0, 8'h00);
        step();
        checks++;
        if (bus.acc_cnt !== {16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd1}) begin
            errors++; $display("[TB] FAIL sweep_counts got %h exp %h", bus.acc_cnt,
                               {16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd1});
        end
        checks++;
        if (bus.out_valid !== 6'b0) begin
            errors++; $display("[TB] FAIL sweep_drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        bus.out_ready = 6'b110111;
        drive(1'b1, 5, 8'h33);
        step();
        exp_cnt[3]++;
        checks++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_data[3*WIDTH +: WIDTH] !== 8'h33) begin
            errors++; $display("[TB] FAIL stall_fill got %b/%h exp 1/33", bus.out_valid[3],
                               bus.out_data[3*WIDTH +: WIDTH]);
        end
        drive(1'b1, 6, 8'h66);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_blocked got %b exp 0", bus.in_ready);
        end
        drive(1'b1, 9, 8'h99);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_other_ready got %b exp 1", bus.in_ready);
        end
        step();
        exp_cnt[4]++;
        checks++;
        if (bus.out_valid !== 6'b011000 || bus.out_data[4*WIDTH +: WIDTH] !== 8'h99 ||
            bus.out_data[3*WIDTH +: WIDTH] !== 8'h33) begin
            errors++; $display("[TB] FAIL stall_bypass got %b ch4 %h ch3 %h exp 011000 99 33",
                               bus.out_valid, bus.out_data[4*WIDTH +: WIDTH], bus.out_data[3*WIDTH +: WIDTH]);
        end
        drive(1'b0, 0, 8'h00);
        bus.out_ready = 6'h3F;
        step();
        checks++;
        if (bus.out_valid !== 6'b0 || bus.acc_cnt !== exp_acc()) begin
            errors++; $display("[TB] FAIL stall_release got %b cnt %h exp 0 cnt %h",
                               bus.out_valid, bus.acc_cnt, exp_acc());
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 6'h3F;
        drive(1'b1, 3, 8'h01);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_ready1 got %b exp 1", bus.in_ready);
        end
        step();
        exp_cnt[2]++;
        checks++;
        if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*WIDTH +: WIDTH] !== 8'h01) begin
            errors++; $display("[TB] FAIL b2b_first got %b/%h exp 1/01", bus.out_valid[2],
                               bus.out_data[2*WIDTH +: WIDTH]);
        end
        drive(1'b1, 3, 8'h02);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_ready2 got %b exp 1", bus.in_ready);
        end
        step();
        exp_cnt[2]++;
        checks++;
        if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*WIDTH +: WIDTH] !== 8'h02 ||
            bus.acc_cnt[2*CNT_W +: CNT_W] !== CNT_W'(exp_cnt[2])) begin
            errors++; $display("[TB] FAIL b2b_second got %b/%h cnt %0d exp 1/02 cnt %0d", bus.out_valid[2],
                               bus.out_data[2*WIDTH +: WIDTH], bus.acc_cnt[2*CNT_W +: CNT_W], exp_cnt[2]);
        end
        drive(1'b0, 0, 8'h00);
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 6'b0;
        drive(1'b1, 0, 8'h10);
        step();
        drive(1'b1, 1, 8'h11);
        step();
        drive(1'b1, 16, 8'h15);
        step();
        exp_cnt[0]++; exp_cnt[1]++; exp_cnt[5]++;
        checks++;
        if (bus.out_valid !== 6'b100011) begin
            errors++; $display("[TB] FAIL flush_fill got %b exp 100011", bus.out_valid);
        end
        drive(1'b1, 2, 8'h77);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_ready got %b exp 0", bus.in_ready);
        end
        step();
        bus.flush = 1'b0;
        drive(1'b0, 0, 8'h00);
        checks++;
        if (bus.out_valid !== 6'b0 || bus.acc_cnt !== exp_acc()) begin
            errors++; $display("[TB] FAIL flush_clear got %b cnt %h exp 0 cnt %h",
                               bus.out_valid, bus.acc_cnt, exp_acc());
        end
        checks++;
        if (bus.out_data[0 +: WIDTH] !== 8'h10 || bus.out_data[5*WIDTH +: WIDTH] !== 8'h15) begin
            errors++; $display("[TB] FAIL flush_buf got %h/%h exp 10/15", bus.out_data[0 +: WIDTH],
                               bus.out_data[5*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_wrap();
        int n;
        bus.out_ready = 6'h3F;
        n = 65535 - exp_cnt[1];
        drive(1'b1, 1, 8'hC1);
        repeat (n) step();
        drive(1'b0, 0, 8'h00);
        step();
        checks++;
        if (bus.acc_cnt[CNT_W +: CNT_W] !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL wrap_max got %h exp ffff", bus.acc_cnt[CNT_W +: CNT_W]);
        end
        drive(1'b1, 1, 8'hC2);
        step();
        drive(1'b0, 0, 8'h00);
        exp_cnt[1] = 0;
        checks++;
        if (bus.acc_cnt[CNT_W +: CNT_W] !== 16'h0000 || bus.acc_cnt !== exp_acc()) begin
            errors++; $display("[TB] FAIL wrap_zero got %h exp %h", bus.acc_cnt, exp_acc());
        end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 6'b0;
        drive(1'b1, 4, 8'h44);
        step();
        drive(1'b1, 8, 8'h88);
        step();
        drive(1'b1, 16, 8'hD5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 6'b0 || bus.out_data !== '0 || bus.acc_cnt !== '0) begin
            errors++; $display("[TB] FAIL async_reset got %b %h %h exp all 0",
                               bus.out_valid, bus.out_data, bus.acc_cnt);
        end
        drive(1'b0, 0, 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) exp_cnt[i] = 0;
        step();
        bus.out_ready = 6'h3F;
        drive(1'b1, 16, 8'hAA);
        step();
        drive(1'b0, 0, 8'h00);
        exp_cnt[5] = 1;
        checks++;
        if (bus.out_valid !== 6'b100000 || bus.out_data[5*WIDTH +: WIDTH] !== 8'hAA ||
            bus.acc_cnt !== exp_acc()) begin
            errors++; $display("[TB] FAIL post_reset got %b %h cnt %h exp 100000 aa cnt %h",
                               bus.out_valid, bus.out_data[5*WIDTH +: WIDTH], bus.acc_cnt, exp_acc());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        data_tab[0] = 8'hB8; data_tab[1] = 8'hF0; data_tab[2] = 8'h55;
        data_tab[3] = 8'h33; data_tab[4] = 8'hE3; data_tab[5] = 8'hAA;
        bus.flush     = 1'b0;
        bus.out_ready = 6'h3F;
        drive(1'b0, 0, 8'h00);
        test_reset();
        test_sweep();
        test_stall();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
